// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared types and constants for the fetch-stage instruction-bus controller.
//   - fetch_state_t : access-tracking states of fetch_ibus_ctrl
//   - fetch_data_t  : fetch-stage payload handed to the D register
//   - FETCH_ADDR_W / FETCH_INSTR_NOP : default PC width and bubble instruction
//   - pc_misaligned() : fetch address-error test on the two PC LSBs
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int          FETCH_ADDR_W    = 32;
  localparam logic [31:0] FETCH_INSTR_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]             instr;
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_ADDR_W-1:0] pcplus4;
    logic                    adel;
  } fetch_data_t;

  // Instruction fetches must be word aligned.
  function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
    return (pc_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_ibus_chk.sv
// -----------------------------------------------------------------------------
// fetch_ibus_chk
//   Protocol checker for the sram-like instruction bus seen by fetch_ibus_ctrl.
//   Tracks whether an access is in flight from the handshakes alone and flags
//   data returned with nothing outstanding, or a second accept while busy.
//   Ports: clk, reset (async, active-high), inst_req, inst_addr_ok,
//          inst_data_ok -- all inputs, observed only.
// -----------------------------------------------------------------------------
module fetch_ibus_chk (
  input  logic clk,
  input  logic reset,
  input  logic inst_req,
  input  logic inst_addr_ok,
  input  logic inst_data_ok
);

  logic outstanding_q;
  logic outstanding_d;

  // An access opens on an accepted request and closes on its data return.
  always_comb begin
    outstanding_d = outstanding_q;
    if (inst_req && inst_addr_ok) begin
      outstanding_d = 1'b1;
    end else if (inst_data_ok) begin
      outstanding_d = 1'b0;
    end else begin
      outstanding_d = outstanding_q;
    end
  end

  // Outstanding-access flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding_q <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
    end
  end

  a_data_needs_outstanding: assert property (
    @(posedge clk) disable iff (reset) inst_data_ok |-> outstanding_q);

  a_single_outstanding: assert property (
    @(posedge clk) disable iff (reset) (inst_req && inst_addr_ok) |-> !outstanding_q);

endmodule

// File: rtl/fetch_ibus_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ibus_ctrl
//   Fetch-stage instruction-bus controller sitting upstream of the D register.
//   Issues one sram-like ibus read for the PC held in the F register, tracks
//   the single outstanding access, discards responses made stale by a PC
//   change, and presents the instruction with pc/pcplus4 to dataF_new.
//   Ports:
//     clk, reset              clock; asynchronous active-high reset
//     pc, stall               F-register PC and stallF from the hazard unit
//     inst_req, inst_addr     ibus request valid / address (= pc)
//     inst_addr_ok            ibus accepted the address this cycle
//     inst_data_ok, inst_rdata ibus read data return
//     i_data_ok               instr is valid for the current pc
//     instr, pcplus4, adel    fetched instruction, pc + 4, fetch address error
// -----------------------------------------------------------------------------
module fetch_ibus_ctrl
  import fetch_pkg::*;
#(
  parameter int          ADDR_W    = FETCH_ADDR_W,
  parameter logic [31:0] INSTR_NOP = FETCH_INSTR_NOP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              stall,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [31:0]       inst_rdata,
  output logic              i_data_ok,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] pcplus4,
  output logic              adel
);

  fetch_state_t      state_q,  state_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [31:0]       ibuf_q,   ibuf_d;

  // The address may change freely until accepted, so it simply follows pc.
  assign inst_addr = pc;
  assign pcplus4   = pc + {{(ADDR_W-3){1'b0}}, 3'd4};

  // Next-state and output decode.
  always_comb begin
    state_d   = state_q;
    req_pc_d  = req_pc_q;
    ibuf_d    = ibuf_q;
    inst_req  = 1'b0;
    i_data_ok = 1'b0;
    instr     = INSTR_NOP;
    adel      = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = REQ;
      end

      REQ: begin
        if (pc_misaligned(pc[1:0])) begin
          // No bus access for a bad address; hand a flagged bubble downstream.
          adel      = 1'b1;
          i_data_ok = 1'b1;
        end else begin
          inst_req = 1'b1;
          if (inst_addr_ok) begin
            req_pc_d = pc;
            state_d  = WAIT;
          end else begin
            state_d = REQ;
          end
        end
      end

      WAIT: begin
        if (inst_data_ok) begin
          state_d = REQ;
          if (pc == req_pc_q) begin
            // Same-cycle pass-through; park the word only if F is held.
            i_data_ok = 1'b1;
            instr     = inst_rdata;
            if (stall) begin
              ibuf_d  = inst_rdata;
              state_d = DONE;
            end else begin
              state_d = REQ;
            end
          end else begin
            // PC moved on while the access was in flight: response is stale.
            state_d = REQ;
          end
        end else begin
          state_d = WAIT;
        end
      end

      DONE: begin
        instr     = ibuf_q;
        i_data_ok = (pc == req_pc_q);
        if (pc != req_pc_q) begin
          ibuf_d  = 32'h0000_0000;
          state_d = REQ;
        end else if (!stall) begin
          state_d = REQ;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, accepted-PC and instruction-buffer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      req_pc_q <= {ADDR_W{1'b0}};
      ibuf_q   <= 32'h0000_0000;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
      ibuf_q   <= ibuf_d;
    end
  end

endmodule

// File: tb/tb_fetch_ibus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ibus_ctrl
//   Self-checking bench for fetch_ibus_ctrl: directed scenarios with literal
//   expectations, then randomized bus/pipeline behaviour compared every cycle
//   against a transaction-level model (in-flight access, held word).
// -----------------------------------------------------------------------------
module tb_fetch_ibus_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        stall;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        i_data_ok;
  logic [31:0] instr;
  logic [31:0] pcplus4;
  logic        adel;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: what the pipeline/bus situation is, not how the DUT encodes it.
  bit          m_idle;      // first cycle after reset release
  bit          m_pend;      // an accepted access awaits its data
  logic [31:0] m_pend_pc;
  int          m_delay;     // bus cycles before data may return
  bit          m_held;      // a returned word is parked for a stalled F
  logic [31:0] m_held_val;
  logic [31:0] m_held_pc;

  fetch_ibus_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .stall        (stall),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .i_data_ok    (i_data_ok),
    .instr        (instr),
    .pcplus4      (pcplus4),
    .adel         (adel)
  );

  fetch_ibus_chk u_chk (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance the model across a rising edge using the inputs seen at that edge.
  task automatic model_update();
    if (reset) begin
      m_idle = 1'b1;
      m_pend = 1'b0;
      m_held = 1'b0;
    end else if (m_idle) begin
      m_idle = 1'b0;
    end else if (m_pend) begin
      if (inst_data_ok) begin
        m_pend = 1'b0;
        if (pc == m_pend_pc && stall) begin
          m_held     = 1'b1;
          m_held_val = inst_rdata;
          m_held_pc  = m_pend_pc;
        end
      end else if (m_delay > 0) begin
        m_delay--;
      end
    end else if (m_held) begin
      if (!stall || pc != m_held_pc) m_held = 1'b0;
    end else if (pc[1:0] == 2'b00 && inst_addr_ok) begin
      m_pend    = 1'b1;
      m_pend_pc = pc;
      m_delay   = $urandom_range(0, 3);
    end
  endtask

  // Compare all DUT outputs with what the model says they must be right now.
  task automatic compare();
    logic        e_req, e_ok, e_adel, chk_instr;
    logic [31:0] e_instr;
    e_req = 1'b0; e_ok = 1'b0; e_adel = 1'b0; chk_instr = 1'b0; e_instr = 32'h0000_0000;
    if (reset || m_idle) begin
      chk_instr = 1'b1;
    end else if (m_pend) begin
      e_ok = inst_data_ok && (pc == m_pend_pc);
      chk_instr = e_ok;
      e_instr = inst_rdata;
    end else if (m_held) begin
      e_ok = (pc == m_held_pc);
      chk_instr = 1'b1;
      e_instr = m_held_val;
    end else if (pc[1:0] != 2'b00) begin
      e_adel = 1'b1;
      e_ok = 1'b1;
      chk_instr = 1'b1;
    end else begin
      e_req = 1'b1;
    end
    chk("model_inst_req", {31'd0, inst_req}, {31'd0, e_req});
    chk("model_i_data_ok", {31'd0, i_data_ok}, {31'd0, e_ok});
    chk("model_adel", {31'd0, adel}, {31'd0, e_adel});
    chk("model_inst_addr", inst_addr, pc);
    chk("model_pcplus4", pcplus4, pc + 32'd4);
    if (chk_instr) chk("model_instr", instr, e_instr);
  endtask

  task automatic step(input logic [31:0] npc, input logic nstall, input logic naok,
                      input logic ndok, input logic [31:0] nrdata, input logic nrst);
    @(posedge clk);
    model_update();
    #2;
    pc = npc; stall = nstall; inst_addr_ok = naok; inst_data_ok = ndok;
    inst_rdata = nrdata; reset = nrst;
    #3;
    compare();
  endtask

  initial begin
    logic [31:0] tmp;
    bit          requesting;
    reset = 1'b1; pc = 32'hBFC0_0000; stall = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0000_0000;
    m_idle = 1'b1; m_pend = 1'b0; m_held = 1'b0; m_delay = 0;
    m_pend_pc = 32'h0; m_held_val = 32'h0; m_held_pc = 32'h0;

    // 1. reset values and basic fetch
    step(32'hBFC0_0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(32'hBFC0_0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("rst_inst_req", {31'd0, inst_req}, 32'd0);
    chk("rst_i_data_ok", {31'd0, i_data_ok}, 32'd0);
    chk("rst_adel", {31'd0, adel}, 32'd0);
    chk("rst_instr", instr, 32'h0000_0000);
    step(32'hBFC0_0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("t1_idle_req", {31'd0, inst_req}, 32'd0);
    step(32'hBFC0_0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("t1_c0_req", {31'd0, inst_req}, 32'd1);
    chk("t1_c0_addr", inst_addr, 32'hBFC0_0000);
    step(32'hBFC0_0000, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("t1_c1_req", {31'd0, inst_req}, 32'd1);
    step(32'hBFC0_0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("t1_c2_req", {31'd0, inst_req}, 32'd0);
    chk("t1_c2_ok", {31'd0, i_data_ok}, 32'd0);
    step(32'hBFC0_0000, 1'b0, 1'b0, 1'b1, 32'h2401_0001, 1'b0);
    chk("t1_c3_ok", {31'd0, i_data_ok}, 32'd1);
    chk("t1_c3_instr", instr, 32'h2401_0001);
    step(32'hBFC0_0004, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("t1_c4_req", {31'd0, inst_req}, 32'd1);
    chk("t1_c4_addr", inst_addr, 32'hBFC0_0004);

    // 2. stalled return held in the buffer
    step(32'hBFC0_0004, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step(32'hBFC0_0004, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(32'hBFC0_0004, 1'b1, 1'b0, 1'b1, 32'h2401_0001, 1'b0);
    chk("t2_data_ok", {31'd0, i_data_ok}, 32'd1);
    for (int k = 0; k < 2; k++) begin
      step(32'hBFC0_0004, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("t2_hold_ok", {31'd0, i_data_ok}, 32'd1);
      chk("t2_hold_instr", instr, 32'h2401_0001);
      chk("t2_hold_req", {31'd0, inst_req}, 32'd0);
    end
    step(32'hBFC0_0004, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("t2_release_ok", {31'd0, i_data_ok}, 32'd1);
    step(32'hBFC0_0008, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("t2_next_req", {31'd0, inst_req}, 32'd1);

    // 3. redirect while waiting drops the stale response
    step(32'hBFC0_0008, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step(32'hBFC0_0380, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(32'hBFC0_0380, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("t3_stale_ok", {31'd0, i_data_ok}, 32'd0);
    step(32'hBFC0_0380, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("t3_re_req", {31'd0, inst_req}, 32'd1);
    chk("t3_re_addr", inst_addr, 32'hBFC0_0380);
    step(32'hBFC0_0380, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step(32'hBFC0_0380, 1'b0, 1'b0, 1'b1, 32'h3C08_BFC0, 1'b0);
    chk("t3_ok", {31'd0, i_data_ok}, 32'd1);
    chk("t3_instr", instr, 32'h3C08_BFC0);

    // 4. slow accept: request held with a stable address
    for (int k = 0; k < 5; k++) begin
      step(32'hBFC0_0384, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("t4_req_held", {31'd0, inst_req}, 32'd1);
      chk("t4_addr_stable", inst_addr, 32'hBFC0_0384);
    end
    step(32'hBFC0_0384, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step(32'hBFC0_0384, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("t4_single_access", {31'd0, inst_req}, 32'd0);
    step(32'hBFC0_0384, 1'b0, 1'b0, 1'b1, 32'hAC01_0008, 1'b0);
    chk("t4_instr", instr, 32'hAC01_0008);

    // 5. misaligned pc and pcplus4 wrap
    step(32'hBFC0_0002, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("t5_req", {31'd0, inst_req}, 32'd0);
    chk("t5_adel", {31'd0, adel}, 32'd1);
    chk("t5_ok", {31'd0, i_data_ok}, 32'd1);
    chk("t5_instr", instr, 32'h0000_0000);
    step(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("t5_pcplus4_wrap", pcplus4, 32'h0000_0000);
    chk("t5_wrap_req", {31'd0, inst_req}, 32'd1);

    // 6. asynchronous reset in the middle of a data-return cycle
    step(32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 32'h8C01_0004, 1'b0);
    chk("t6_pre_ok", {31'd0, i_data_ok}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("t6_async_ok", {31'd0, i_data_ok}, 32'd0);
    chk("t6_async_req", {31'd0, inst_req}, 32'd0);
    chk("t6_async_instr", instr, 32'h0000_0000);
    step(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("t6_idle_req", {31'd0, inst_req}, 32'd0);
    step(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("t6_after_req", {31'd0, inst_req}, 32'd1);

    // Randomized pipeline and bus behaviour against the model.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      model_update();
      #2;
      if (reset) begin
        reset = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
      end else begin
        // F advances when it was not stalled at this edge; rare forced redirect.
        if (!stall || $urandom_range(0, 99) < 4) begin
          tmp = $urandom_range(0, 99);
          if (tmp < 65) begin
            pc = pc + 32'd4;
          end else if (tmp < 85) begin
            pc = {$urandom() & 32'hFFFF_FFFC};
          end else if (tmp < 93) begin
            tmp = $urandom();
            tmp[1:0] = 2'($urandom_range(1, 3));
            pc = tmp;
          end else begin
            pc = 32'hFFFF_FFFC;
          end
        end
        stall = ($urandom_range(0, 99) < 40);
        requesting = !m_idle && !m_pend && !m_held;
        inst_addr_ok = requesting && (pc[1:0] == 2'b00) && ($urandom_range(0, 99) < 45);
        inst_data_ok = m_pend && (m_delay == 0) && ($urandom_range(0, 99) < 60);
        inst_rdata = $urandom();
        if ($urandom_range(0, 999) < 5) begin
          reset = 1'b1;
          inst_addr_ok = 1'b0;
          inst_data_ok = 1'b0;
        end
      end
      #3;
      compare();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
